majority_vote_ctrl: RTL and testbench

MAJORITY_VOTE_CTRL -- requirements
Module: majority_vote_ctrl

---
 rtl/majority_pkg.sv | 28 ++
 rtl/majority_4bit.sv | 20 ++
 rtl/majority_vote_ctrl.sv | 137 +++++++++++++
 tb/tb_majority_vote_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/majority_pkg.sv
// majority_pkg
//   Shared definitions for the four-voter majority ballot controller.
//   Contents:
//     NVOTERS     - number of voters taking part in each ballot
//     state_e     - controller FSM states
//     countOnes() - population count of a ballot word
package majority_pkg;

  localparam int NVOTERS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DECIDE,
    ST_OUT
  } state_e;

  // Number of yes votes in a ballot word. Three bits are enough to hold 0..4.
  function automatic logic [2:0] countOnes(input logic [NVOTERS-1:0] vec);
    logic [2:0] total;
    total = '0;
    for (int i = 0; i < NVOTERS; i++) begin
      total = total + {2'b00, vec[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/majority_4bit.sv
// majority_4bit
//   Purely combinational 4-input majority: Y is high when at least three of
//   the four bits of A are high.
//   Ports:
//     A - input  [3:0] ballot word, one bit per voter
//     Y - output       1 when at least three bits of A are 1
module majority_4bit
  import majority_pkg::*;
(
  input  logic [NVOTERS-1:0] A,
  output logic               Y
);

  // At least three ones means some group of three bits is all ones.
  assign Y = (A[0] & A[1] & A[2]) |
             (A[0] & A[1] & A[3]) |
             (A[0] & A[2] & A[3]) |
             (A[1] & A[2] & A[3]);

endmodule

// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl
//   Runs one four-voter ballot at a time: opens on start, latches the first
//   vote from each voter during a bounded collection window, decides the
//   majority and holds the result until the consumer accepts it.
//   Parameters:
//     WINDOW       - maximum collection cycles per ballot (2..255)
//   Ports:
//     clk          - input        clock, rising edge
//     rst          - input        asynchronous active-high reset
//     start        - input        opens a ballot (honoured only when idle)
//     vote_valid   - input  [3:0] per-voter vote strobe
//     vote_val     - input  [3:0] per-voter vote value
//     busy         - output       a ballot is in progress
//     result_valid - output       result available
//     result_ready - input        consumer accepts the result
//     result       - output       majority decision (three or more yes)
//     tie          - output       exactly two yes votes
//     timeout      - output       ballot closed by window expiry
//     voted_mask   - output [3:0] voters whose vote was latched
module majority_vote_ctrl
  import majority_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NVOTERS-1:0] vote_valid,
  input  logic [NVOTERS-1:0] vote_val,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               result,
  output logic               tie,
  output logic               timeout,
  output logic [NVOTERS-1:0] voted_mask
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

  state_e             state_q;
  logic [NVOTERS-1:0] ballot_q;
  logic [NVOTERS-1:0] voteMask_q;
  logic [CW-1:0]      winCnt_q;
  logic               busy_q;
  logic               resultValid_q;
  logic               result_q;
  logic               tie_q;
  logic               timeout_q;

  logic [NVOTERS-1:0] newVotes;
  logic [NVOTERS-1:0] voteMask_d;
  logic [NVOTERS-1:0] ballot_d;
  logic               majority;

  // Only voters that have not yet voted can land a vote; this is what makes
  // the first vote win. The completion test uses the merged mask so a vote
  // arriving this cycle can close the ballot on the same edge.
  assign newVotes   = vote_valid & ~voteMask_q;
  assign voteMask_d = voteMask_q | newVotes;
  assign ballot_d   = (ballot_q & ~newVotes) | (vote_val & newVotes);

  majority_4bit uMajority (
    .A (ballot_q),
    .Y (majority)
  );

  // Controller FSM. Every output is a register updated here, so no input
  // reaches an output without passing through a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ballot_q      <= '0;
      voteMask_q    <= '0;
      winCnt_q      <= '0;
      busy_q        <= 1'b0;
      resultValid_q <= 1'b0;
      result_q      <= 1'b0;
      tie_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_COLLECT;
            ballot_q   <= '0;
            voteMask_q <= '0;
            winCnt_q   <= '0;
            busy_q     <= 1'b1;
            timeout_q  <= 1'b0;
          end
        end
        ST_COLLECT: begin
          ballot_q   <= ballot_d;
          voteMask_q <= voteMask_d;
          winCnt_q   <= winCnt_q + CW'(1);
          // A full mask takes priority, so a last vote landing on the final
          // window cycle is not reported as a timeout.
          if (&voteMask_d) begin
            state_q   <= ST_DECIDE;
            timeout_q <= 1'b0;
          end else if (winCnt_q == LAST_CNT) begin
            state_q   <= ST_DECIDE;
            timeout_q <= 1'b1;
          end
        end
        ST_DECIDE: begin
          // Unlatched voters stay 0 in the ballot, so they count as no.
          result_q      <= majority;
          tie_q         <= (countOnes(ballot_q) == 3'd2);
          resultValid_q <= 1'b1;
          state_q       <= ST_OUT;
        end
        ST_OUT: begin
          if (result_ready) begin
            resultValid_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = resultValid_q;
  assign result       = result_q;
  assign tie          = tie_q;
  assign timeout      = timeout_q;
  assign voted_mask   = voteMask_q;

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl
//   Directed bench for majority_vote_ctrl. A default instance (WINDOW=16)
//   covers the main ballot behaviour; a second instance with WINDOW=4 covers
//   window expiry. Inputs change 1 ns after a rising edge and outputs are
//   observed at the same point, well away from the next active edge.
//   Observed word layout: {busy, result_valid, result, tie, timeout, mask[3:0]}.
module tb_majority_vote_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] voteValid;
  logic [3:0] voteVal;
  logic       resultReady;
  logic       busy;
  logic       resultValid;
  logic       result;
  logic       tie;
  logic       timeout;
  logic [3:0] votedMask;

  logic       start4;
  logic [3:0] voteValid4;
  logic [3:0] voteVal4;
  logic       resultReady4;
  logic       busy4;
  logic       resultValid4;
  logic       result4;
  logic       tie4;
  logic       timeout4;
  logic [3:0] votedMask4;

  int checks;
  int errors;

  majority_vote_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vote_valid   (voteValid),
    .vote_val     (voteVal),
    .busy         (busy),
    .result_valid (resultValid),
    .result_ready (resultReady),
    .result       (result),
    .tie          (tie),
    .timeout      (timeout),
    .voted_mask   (votedMask)
  );

  majority_vote_ctrl #(.WINDOW(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .start        (start4),
    .vote_valid   (voteValid4),
    .vote_val     (voteVal4),
    .busy         (busy4),
    .result_valid (resultValid4),
    .result_ready (resultReady4),
    .result       (result4),
    .tie          (tie4),
    .timeout      (timeout4),
    .voted_mask   (votedMask4)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {busy, resultValid, result, tie, timeout, votedMask};
  endfunction

  function automatic logic [8:0] obs4();
    return {busy4, resultValid4, result4, tie4, timeout4, votedMask4};
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'b0_0_0_0_0_0000) begin
      errors++;
      $display("[TB] FAIL reset_async: got %b expected %b", obs(), 9'b0);
    end
    tick();
    checks++;
    if (obs4() !== 9'b0_0_0_0_0_0000) begin
      errors++;
      $display("[TB] FAIL reset_dut4: got %b expected %b", obs4(), 9'b0);
    end
    rst = 1'b0;
  endtask

  // All four votes in the cycle after start; ballot 0111.
  task automatic test_basic();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs() !== 9'b1_0_0_0_0_0000) begin
      errors++;
      $display("[TB] FAIL basic_collect: got %b expected %b", obs(), 9'b1_0_0_0_0_0000);
    end
    voteValid = 4'b1111;
    voteVal   = 4'b0111;
    tick();
    voteValid = 4'b0000;
    checks++;
    if (obs() !== 9'b1_0_0_0_0_1111) begin
      errors++;
      $display("[TB] FAIL basic_decide: got %b expected %b", obs(), 9'b1_0_0_0_0_1111);
    end
    tick();
    checks++;
    if (obs() !== 9'b1_1_1_0_0_1111) begin
      errors++;
      $display("[TB] FAIL basic_out: got %b expected %b", obs(), 9'b1_1_1_0_0_1111);
    end
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    checks++;
    if ({busy, resultValid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL basic_accept: got %b expected %b", {busy, resultValid}, 2'b00);
    end
  endtask

  // One vote per cycle, ballot 1100 -> tie.
  task automatic test_spread();
    logic [3:0] strobes [4];
    logic [3:0] values  [4];
    strobes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    values  = '{4'b0000, 4'b0000, 4'b0100, 4'b1000};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      voteValid = strobes[i];
      voteVal   = values[i];
      tick();
    end
    voteValid = 4'b0000;
    voteVal   = 4'b0000;
    checks++;
    if (resultValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spread_early: got %b expected %b", resultValid, 1'b0);
    end
    tick();
    checks++;
    if (obs() !== 9'b1_1_0_1_0_1111) begin
      errors++;
      $display("[TB] FAIL spread_out: got %b expected %b", obs(), 9'b1_1_0_1_0_1111);
    end
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
  endtask

  // Voter 1 votes 1 then 0; the second vote must be ignored.
  task automatic test_repeat();
    start = 1'b1;
    tick();
    start = 1'b0;
    voteValid = 4'b0010;
    voteVal   = 4'b0010;
    tick();
    voteValid = 4'b0010;
    voteVal   = 4'b0000;
    tick();
    checks++;
    if (votedMask !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL repeat_mask: got %b expected %b", votedMask, 4'b0010);
    end
    voteValid = 4'b1101;
    voteVal   = 4'b0101;
    tick();
    voteValid = 4'b0000;
    voteVal   = 4'b0000;
    tick();
    checks++;
    if (obs() !== 9'b1_1_1_0_0_1111) begin
      errors++;
      $display("[TB] FAIL repeat_out: got %b expected %b", obs(), 9'b1_1_1_0_0_1111);
    end
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
  endtask

  // Result held while the consumer stalls; start and votes ignored in OUT,
  // and a start coinciding with acceptance is ignored too.
  task automatic test_back_to_back();
    start = 1'b1;
    tick();
    start = 1'b0;
    voteValid = 4'b1111;
    voteVal   = 4'b0011;
    tick();
    voteValid = 4'b0000;
    voteVal   = 4'b0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      start       = i[0] ? 1'b0 : 1'b1;
      voteValid   = 4'b1111;
      voteVal     = 4'b1111;
      resultReady = 1'b0;
      tick();
      checks++;
      if (obs() !== 9'b1_1_0_1_0_1111) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got %b expected %b", i, obs(), 9'b1_1_0_1_0_1111);
      end
    end
    start       = 1'b1;
    resultReady = 1'b1;
    tick();
    start       = 1'b0;
    resultReady = 1'b0;
    voteValid   = 4'b0000;
    voteVal     = 4'b0000;
    checks++;
    if ({busy, resultValid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_accept: got %b expected %b", {busy, resultValid}, 2'b00);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_no_new_ballot: got %b expected %b", busy, 1'b0);
    end
  endtask

  // WINDOW=4, only voter 0 votes 1 -> closed by expiry after 4 COLLECT cycles.
  task automatic test_timeout();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    voteValid4 = 4'b0001;
    voteVal4   = 4'b0001;
    tick();
    voteValid4 = 4'b0000;
    voteVal4   = 4'b0000;
    tick();
    tick();
    checks++;
    if ({busy4, resultValid4} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL timeout_collect: got %b expected %b", {busy4, resultValid4}, 2'b10);
    end
    tick();
    checks++;
    if (resultValid4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_decide: got %b expected %b", resultValid4, 1'b0);
    end
    tick();
    checks++;
    if (obs4() !== 9'b1_1_0_0_1_0001) begin
      errors++;
      $display("[TB] FAIL timeout_out: got %b expected %b", obs4(), 9'b1_1_0_0_1_0001);
    end
    resultReady4 = 1'b1;
    tick();
    resultReady4 = 1'b0;
  endtask

  // WINDOW=4, last vote lands on the final window cycle -> no timeout.
  task automatic test_coincide();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    voteValid4 = 4'b0111;
    voteVal4   = 4'b0111;
    tick();
    voteValid4 = 4'b0000;
    voteVal4   = 4'b0000;
    tick();
    tick();
    voteValid4 = 4'b1000;
    voteVal4   = 4'b1000;
    tick();
    voteValid4 = 4'b0000;
    voteVal4   = 4'b0000;
    tick();
    checks++;
    if (obs4() !== 9'b1_1_1_0_0_1111) begin
      errors++;
      $display("[TB] FAIL coincide_out: got %b expected %b", obs4(), 9'b1_1_1_0_0_1111);
    end
    resultReady4 = 1'b1;
    tick();
    resultReady4 = 1'b0;
  endtask

  // Reset mid-ballot discards the votes; the next ballot starts clean.
  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    voteValid = 4'b0011;
    voteVal   = 4'b0011;
    tick();
    voteValid = 4'b0000;
    voteVal   = 4'b0000;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 9'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %b expected %b", obs(), 9'b0);
    end
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs() !== 9'b1_0_0_0_0_0000) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got %b expected %b", obs(), 9'b1_0_0_0_0_0000);
    end
    voteValid = 4'b1100;
    voteVal   = 4'b1100;
    tick();
    voteValid = 4'b0000;
    voteVal   = 4'b0000;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (resultValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_window: got %b expected %b", resultValid, 1'b0);
    end
    tick();
    checks++;
    if (obs() !== 9'b1_1_0_1_1_1100) begin
      errors++;
      $display("[TB] FAIL midreset_out: got %b expected %b", obs(), 9'b1_1_0_1_1_1100);
    end
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    start        = 1'b0;
    voteValid    = 4'b0000;
    voteVal      = 4'b0000;
    resultReady  = 1'b0;
    start4       = 1'b0;
    voteValid4   = 4'b0000;
    voteVal4     = 4'b0000;
    resultReady4 = 1'b0;
    test_reset();
    test_basic();
    test_spread();
    test_repeat();
    test_back_to_back();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
